ce_divchain: RTL and testbench
==============================

# ce_divchain

Parametrised clock-enable divider chain for the free-running internal oscillator domain (~4.6 MHz). It produces three nested, phase-aligned single-cycle enable strobes (base, mid, slow) and supports a runtime-trimmable base divider for oscillator calibration. It also provides a synchronous re-phase input and a global run enable. Consumers (RTC tick, debounce, watchdog, blink logic) use these strobes instead of local counters.

## Interface
- BASE_W, 8, width of base divider and trim value
- BASE_DIV_RESET, 8'd144, base terminal count after reset (period = value + 1 clk)
- MID_DIV, 4096, base strobes per mid strobe (>= 1)
- SLOW_DIV, 8, mid strobes per slow strobe (>= 1)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  run enable; 0 freezes all counters
- sync  in  1  single-cycle re-phase request
- trim_val  in  BASE_W  new base terminal count
- trim_load  in  1  single-cycle strobe; latch trim_val
- trim_busy  out  1  trim value latched but not yet applied
- ce_base  out  1  base strobe, 1 clk wide
- ce_mid  out  1  mid strobe, 1 clk wide
- ce_slow  out  1  slow strobe, 1 clk wide

## Operation
- Reset values: base_cnt=0, mid_cnt=0, slow_cnt=0, div=BASE_DIV_RESET, shadow=0, trim_busy=0, all ce_* = 0.
- Counter widths: base_cnt BASE_W bits; mid_cnt/slow_cnt $clog2 of their divisor (min 1 bit).
- Base: when en=1, base_cnt increments. Base wrap = en && base_cnt==div. On wrap: base_cnt<=0, ce_base<=1.
- Mid: on base wrap, if mid_cnt==MID_DIV-1 then mid_cnt<=0, ce_mid<=1, else mid_cnt+1.
- Slow: on mid wrap, same rule with SLOW_DIV, driving ce_slow.
- Nesting: ce_slow=1 implies ce_mid=1 implies ce_base=1 in the same cycle.
- All ce_* default to 0 every cycle they are not set.
- en=0: counters hold, ce_* = 0, trim_load still captured; pending trim is not applied.
- Trim: trim_load=1 -> shadow<=trim_val, trim_busy<=1. Applied at the next base wrap: div<=shadow, trim_busy<=0. A wrap in the same cycle as trim_load uses the old div and old pending state; the new value applies at the following wrap. A second trim_load while busy overwrites shadow.
- trim_val=0: ce_base asserts every enabled cycle.
- Sync: all counters <=0, ce_* <=0. If trim_busy, div<=shadow and trim_busy<=0. Sync has priority over wrap. trim_load coincident with sync is captured as pending and not applied.
- Reset mid-operation: immediate return to reset values; the trim value is lost.

## Timing
- ce_base rises the cycle after the edge where base_cnt==div; strobe period = div+1 enabled cycles.
- First ce_base after reset/sync release: clk edge number div+1 (counting from first enabled edge).
- ce_mid period = MID_DIV*(div+1); ce_slow period = SLOW_DIV*MID_DIV*(div+1).
- Trim latency: trim_busy rises 1 clk after trim_load and falls on the applying wrap edge.
- All outputs registered; no combinational input-to-output path.

## Configuration
- CE_DIVCHAIN_TRIM_EN defined: trim_val/trim_load/trim_busy are functional as above.
- Not defined: div is constant BASE_DIV_RESET, shadow logic removed, trim_load/trim_val ignored, trim_busy tied 0; sync and en behave unchanged.

## Test plan
- Reset, en=1, defaults: ce_base every 145 clk; ce_mid every 593920 clk; ce_slow every 4751360 clk, coincident with ce_mid and ce_base.
- BASE_DIV_RESET=3, MID_DIV=4, SLOW_DIV=3: ce_base every 4 clk, ce_mid every 16, ce_slow every 48; check nesting on every strobe.
- trim_load with trim_val=9 mid-period (div=3): trim_busy=1 until next wrap; the period that follows is 10 clk. A load on a wrap cycle takes effect one wrap later. Without the macro, the period stays 4 and trim_busy=0.
- sync at base_cnt=2 while trim pending (shadow=5): counters cleared, no strobe that cycle; the next ce_base comes 6 clk later and trim_busy drops.
- en low for 20 clk mid-period: no strobes, counters hold; the period resumes with remaining count intact. A trim_load during freeze stays pending.
- Assert rst asynchronously mid-count: all outputs 0 immediately without a clk edge, div=BASE_DIV_RESET, and the first ce_base arrives after release per the period rule.

Source files
------------

// File: rtl/ce_divchain.sv
// ce_divchain: nested clock-enable strobe generator (base/mid/slow) for the
// internal oscillator domain, with optional runtime trim of the base divider.
//
// Optional feature macro: CE_DIVCHAIN_TRIM_EN
//   defined     -> trim_val/trim_load/trim_busy are functional
//   not defined -> base divider fixed at BASE_DIV_RESET, trim_busy tied 0
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   en         run enable; 0 freezes all counters and suppresses strobes
//   sync       single-cycle re-phase request (clears all counters)
//   trim_val   new base terminal count
//   trim_load  single-cycle strobe capturing trim_val as pending
//   trim_busy  a trim value is pending and not yet applied
//   ce_base    base strobe, period div+1 enabled cycles
//   ce_mid     mid strobe, every MID_DIV base strobes
//   ce_slow    slow strobe, every SLOW_DIV mid strobes
module ce_divchain #(
   parameter int unsigned        BASE_W         = 8,
   parameter logic [BASE_W-1:0]  BASE_DIV_RESET = BASE_W'(144),
   parameter int unsigned        MID_DIV        = 4096,
   parameter int unsigned        SLOW_DIV       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              sync,
   input  logic [BASE_W-1:0] trim_val,
   input  logic              trim_load,
   output logic              trim_busy,
   output logic              ce_base,
   output logic              ce_mid,
   output logic              ce_slow
);

   localparam int MID_W  = (MID_DIV  > 1) ? $clog2(MID_DIV)  : 1;
   localparam int SLOW_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

   localparam logic [MID_W-1:0]  MID_LAST  = MID_W'(MID_DIV - 1);
   localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_DIV - 1);

   logic [BASE_W-1:0] base_cnt_q, base_cnt_d;
   logic [MID_W-1:0]  mid_cnt_q,  mid_cnt_d;
   logic [SLOW_W-1:0] slow_cnt_q, slow_cnt_d;
   logic              ce_base_q,  ce_base_d;
   logic              ce_mid_q,   ce_mid_d;
   logic              ce_slow_q,  ce_slow_d;
   logic [BASE_W-1:0] div_q;

   logic base_wrap;
   logic mid_wrap;
   logic slow_wrap;

   // Wraps are nested: a higher stage can only wrap on a lower-stage wrap.
   assign base_wrap = en && (base_cnt_q == div_q);
   assign mid_wrap  = base_wrap && (mid_cnt_q == MID_LAST);
   assign slow_wrap = mid_wrap && (slow_cnt_q == SLOW_LAST);

   always_comb begin
      base_cnt_d = base_cnt_q;
      mid_cnt_d  = mid_cnt_q;
      slow_cnt_d = slow_cnt_q;
      ce_base_d  = 1'b0;
      ce_mid_d   = 1'b0;
      ce_slow_d  = 1'b0;
      if (sync) begin
         // Re-phase wins over any wrap in the same cycle.
         base_cnt_d = '0;
         mid_cnt_d  = '0;
         slow_cnt_d = '0;
      end else if (en) begin
         ce_base_d = base_wrap;
         ce_mid_d  = mid_wrap;
         ce_slow_d = slow_wrap;
         if (base_wrap) begin
            base_cnt_d = '0;
            if (mid_wrap) begin
               mid_cnt_d = '0;
               if (slow_wrap) begin
                  slow_cnt_d = '0;
               end else begin
                  slow_cnt_d = slow_cnt_q + SLOW_W'(1);
               end
            end else begin
               mid_cnt_d = mid_cnt_q + MID_W'(1);
            end
         end else begin
            base_cnt_d = base_cnt_q + BASE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_cnt_q <= '0;
         mid_cnt_q  <= '0;
         slow_cnt_q <= '0;
         ce_base_q  <= 1'b0;
         ce_mid_q   <= 1'b0;
         ce_slow_q  <= 1'b0;
      end else begin
         base_cnt_q <= base_cnt_d;
         mid_cnt_q  <= mid_cnt_d;
         slow_cnt_q <= slow_cnt_d;
         ce_base_q  <= ce_base_d;
         ce_mid_q   <= ce_mid_d;
         ce_slow_q  <= ce_slow_d;
      end
   end

`ifdef CE_DIVCHAIN_TRIM_EN
   logic [BASE_W-1:0] shadow_q, shadow_d;
   logic [BASE_W-1:0] div_d;
   logic              busy_q,   busy_d;
   logic              apply;

   // A pending value is applied only at a wrap or re-phase, where base_cnt
   // restarts at 0, so the new divider never sees a count beyond itself.
   // apply uses the pending state from before this cycle's trim_load.
   assign apply = (sync || base_wrap) && busy_q;

   always_comb begin
      shadow_d = shadow_q;
      div_d    = div_q;
      busy_d   = busy_q;
      if (apply) begin
         div_d  = shadow_q;
         busy_d = 1'b0;
      end
      if (trim_load) begin
         shadow_d = trim_val;
         busy_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= '0;
         div_q    <= BASE_DIV_RESET;
         busy_q   <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         div_q    <= div_d;
         busy_q   <= busy_d;
      end
   end

   assign trim_busy = busy_q;
`else
   logic unused_trim;

   assign unused_trim = ^{trim_val, trim_load};
   assign div_q       = BASE_DIV_RESET;
   assign trim_busy   = 1'b0;
`endif

   assign ce_base = ce_base_q;
   assign ce_mid  = ce_mid_q;
   assign ce_slow = ce_slow_q;

endmodule

// File: tb/tb_ce_divchain.sv
// tb_ce_divchain: directed + randomized bench for ce_divchain using a
// strobe-count reference model (elapsed enabled cycles, strobe ordinals).
module tb_ce_divchain;

   localparam int BW   = 8;
   localparam int DRST = 3;
   localparam int MD   = 4;
   localparam int SD   = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          sync;
   logic [BW-1:0] trim_val;
   logic          trim_load;
   logic          trim_busy;
   logic          ce_base;
   logic          ce_mid;
   logic          ce_slow;

   int checks = 0;
   int errors = 0;

   // Reference model state: current period length, pending trim, enabled
   // cycles since the last strobe/re-phase, base strobes since re-phase.
   int m_div;
   int m_shadow;
   bit m_busy;
   int m_elapsed;
   int m_nbase;
   bit x_base;
   bit x_mid;
   bit x_slow;

   always #5 clk = ~clk;

   ce_divchain #(
      .BASE_W         (BW),
      .BASE_DIV_RESET (BW'(DRST)),
      .MID_DIV        (MD),
      .SLOW_DIV       (SD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .sync      (sync),
      .trim_val  (trim_val),
      .trim_load (trim_load),
      .trim_busy (trim_busy),
      .ce_base   (ce_base),
      .ce_mid    (ce_mid),
      .ce_slow   (ce_slow)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_div     = DRST;
      m_shadow  = 0;
      m_busy    = 1'b0;
      m_elapsed = 0;
      m_nbase   = 0;
      x_base    = 1'b0;
      x_mid     = 1'b0;
      x_slow    = 1'b0;
   endtask

   task automatic model_edge(input bit i_en, input bit i_sync,
                             input bit i_tl, input int i_tv);
      bit fire;
      fire   = 1'b0;
      x_base = 1'b0;
      x_mid  = 1'b0;
      x_slow = 1'b0;
      if (i_sync) begin
         m_elapsed = 0;
         m_nbase   = 0;
         fire      = 1'b1;
      end else if (i_en) begin
         m_elapsed++;
         if (m_elapsed == m_div + 1) begin
            m_elapsed = 0;
            m_nbase++;
            x_base = 1'b1;
            x_mid  = (m_nbase % MD) == 0;
            x_slow = (m_nbase % (MD * SD)) == 0;
            fire   = 1'b1;
         end
      end
`ifdef CE_DIVCHAIN_TRIM_EN
      if (fire && m_busy) begin
         m_div  = m_shadow;
         m_busy = 1'b0;
      end
      if (i_tl) begin
         m_shadow = i_tv;
         m_busy   = 1'b1;
      end
`else
      if (fire && i_tl && i_tv < 0) m_busy = 1'b0;
`endif
   endtask

   task automatic check_outs(input string ph);
      chk({ph, "_ce_base"}, 32'(ce_base), 32'(x_base));
      chk({ph, "_ce_mid"}, 32'(ce_mid), 32'(x_mid));
      chk({ph, "_ce_slow"}, 32'(ce_slow), 32'(x_slow));
      chk({ph, "_trim_busy"}, 32'(trim_busy), 32'(m_busy));
      chk({ph, "_nest_mid"}, 32'(ce_mid & ~ce_base), 32'(0));
      chk({ph, "_nest_slow"}, 32'(ce_slow & ~ce_mid), 32'(0));
   endtask

   task automatic step(input string ph);
      @(posedge clk);
      model_edge(en, sync, trim_load, int'(trim_val));
      #1;
      check_outs(ph);
   endtask

   task automatic run(input string ph, input int n);
      for (int i = 0; i < n; i++) step(ph);
   endtask

   // Advance until the model says the next enabled edge lands on `target`
   // elapsed cycles; bounded so a broken model cannot hang the run.
   task automatic run_to(input string ph, input int target);
      for (int i = 0; i < 300; i++) begin
         if (m_elapsed == target) return;
         step(ph);
      end
      chk({ph, "_run_to_bound"}, 32'(m_elapsed), 32'(target));
   endtask

   initial begin
      rst       = 1'b1;
      en        = 1'b0;
      sync      = 1'b0;
      trim_load = 1'b0;
      trim_val  = '0;
      model_reset();
      #12;
      check_outs("reset");

      @(negedge clk);
      rst = 1'b0;
      en  = 1'b1;
      run("defaults", 60);

      // Trim to 9 in the middle of a period.
      run_to("trim_mid", 1);
      trim_val  = 8'd9;
      trim_load = 1'b1;
      step("trim_mid");
      trim_load = 1'b0;
      run("trim_mid", 30);

      // Trim load exactly on a wrap cycle: applies one wrap later.
      run_to("trim_wrap", m_div);
      trim_val  = 8'd2;
      trim_load = 1'b1;
      step("trim_wrap");
      trim_load = 1'b0;
      run("trim_wrap", 30);

      // Re-phase at base_cnt=2 with shadow=5 pending.
      run_to("sync", 0);
      trim_val  = 8'd5;
      trim_load = 1'b1;
      step("sync");
      trim_load = 1'b0;
      run_to("sync", 2);
      sync = 1'b1;
      step("sync");
      sync = 1'b0;
      run("sync", 20);

      // Freeze mid-period with a trim_load during the freeze.
      run_to("freeze", 3);
      en = 1'b0;
      run("freeze", 5);
      trim_val  = 8'd6;
      trim_load = 1'b1;
      step("freeze");
      trim_load = 1'b0;
      run("freeze", 14);
      en = 1'b1;
      run("freeze", 40);

      // trim_val = 0: strobe every enabled cycle.
      trim_val  = 8'd0;
      trim_load = 1'b1;
      step("trim_zero");
      trim_load = 1'b0;
      run("trim_zero", 30);

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         en        = ($urandom % 8) != 0;
         sync      = ($urandom % 50) == 0;
         trim_load = ($urandom % 20) == 0;
         trim_val  = BW'($urandom_range(0, 12));
         step("rand");
      end
      en        = 1'b1;
      sync      = 1'b0;
      trim_load = 1'b0;
      run("settle", 20);

      // Asynchronous reset between clock edges.
      run_to("async_rst", 2);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_outs("async_rst");
      @(negedge clk);
      rst = 1'b0;
      run("after_rst", 60);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
